// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared state encoding and arithmetic helpers for the fully-connected layer engine
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    STORE,
    DONE
  } fc_state_t;

  // Width wide enough to carry any accumulator the engine is built with
  localparam int SAT_W = 128;

  // Clamp a signed value into the range of an out_w-bit signed number
  function automatic logic signed [SAT_W-1:0] fc_sat(input logic signed [SAT_W-1:0] val,
                                                     input int out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
    lo = ~hi;
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

  // Negative values become zero
  function automatic logic signed [SAT_W-1:0] fc_relu(input logic signed [SAT_W-1:0] val);
    return (val < 0) ? '0 : val;
  endfunction

endpackage

// File: rtl/fc_mac_lanes.sv
// rtl/fc_mac_lanes.sv - combinational LANES-wide multiply and sum for one input chunk
module fc_mac_lanes #(
  parameter int LANES = 8,
  parameter int IN_W  = 32,
  parameter int WGT_W = 8,
  parameter int ACC_W = 48
) (
  input  logic signed [IN_W-1:0]  in_lane  [0:LANES-1],
  input  logic signed [WGT_W-1:0] wgt_lane [0:LANES-1],
  output logic signed [ACC_W-1:0] psum
);

  localparam int PROD_W = IN_W + WGT_W;

  logic signed [PROD_W-1:0] prod [0:LANES-1];

  // Full-width signed products, operands sign-extended before multiplying
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod[k] = PROD_W'(in_lane[k]) * PROD_W'(wgt_lane[k]);
    end
  end

  // Sum of all lane products at accumulator width
  always_comb begin
    psum = '0;
    for (int k = 0; k < LANES; k++) begin
      psum = psum + ACC_W'(prod[k]);
    end
  end

endmodule

// File: rtl/fc_layer_seq.sv
// rtl/fc_layer_seq.sv - sequential fully-connected layer with saturation and argmax; optional ReLU via FC_RELU_EN
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int IN_DIM  = 128,
  parameter int OUT_DIM = 10,
  parameter int LANES   = 8,
  parameter int IN_W    = 32,
  parameter int WGT_W   = 8,
  parameter int BIAS_W  = 32,
  parameter int ACC_W   = 48,
  parameter int OUT_W   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic signed [IN_W-1:0]      in_vec  [0:IN_DIM-1],
  input  logic signed [WGT_W-1:0]     weights [0:OUT_DIM-1][0:IN_DIM-1],
  input  logic signed [BIAS_W-1:0]    biases  [0:OUT_DIM-1],
  output logic signed [OUT_W-1:0]     out_vec [0:OUT_DIM-1],
  output logic [$clog2(OUT_DIM)-1:0]  class_idx
);

  localparam int NCHUNK = IN_DIM / LANES;
  localparam int CH_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NEU_W  = $clog2(OUT_DIM);
  localparam int IDX_W  = $clog2(IN_DIM);

  localparam logic [CH_W-1:0]  LAST_CHUNK  = CH_W'(NCHUNK - 1);
  localparam logic [NEU_W-1:0] LAST_NEURON = NEU_W'(OUT_DIM - 1);

  if (IN_DIM % LANES != 0) begin : g_bad_lanes
    $error("fc_layer_seq: IN_DIM must be a multiple of LANES");
  end
  if (ACC_W < IN_W + WGT_W + $clog2(IN_DIM) + 1) begin : g_bad_acc
    $error("fc_layer_seq: ACC_W too narrow for worst-case dot product");
  end

  fc_state_t                 state;
  logic [NEU_W-1:0]          neuron;
  logic [CH_W-1:0]           chunk;
  logic signed [ACC_W-1:0]   acc;
  logic signed [OUT_W-1:0]   max_val;

  logic signed [IN_W-1:0]    lane_in  [0:LANES-1];
  logic signed [WGT_W-1:0]   lane_wgt [0:LANES-1];
  logic signed [ACC_W-1:0]   lane_sum;
  logic signed [OUT_W-1:0]   store_val;

  // Route the current chunk of inputs and the current neuron's weights to the lanes
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < LANES; k++) begin
      idx         = IDX_W'(int'(chunk) * LANES + k);
      lane_in[k]  = in_vec[idx];
      lane_wgt[k] = weights[neuron][idx];
    end
  end

  fc_mac_lanes #(
    .LANES (LANES),
    .IN_W  (IN_W),
    .WGT_W (WGT_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .in_lane  (lane_in),
    .wgt_lane (lane_wgt),
    .psum     (lane_sum)
  );

  // Value written to out_vec on STORE; argmax compares this same value
  always_comb begin
    logic signed [SAT_W-1:0] acc_ext;
    acc_ext = SAT_W'(acc);
`ifdef FC_RELU_EN
    store_val = OUT_W'(fc_relu(fc_sat(acc_ext, OUT_W)));
`else
    store_val = OUT_W'(fc_sat(acc_ext, OUT_W));
`endif
  end

  // Control FSM with counters, accumulator, outputs and running argmax
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      neuron    <= '0;
      chunk     <= '0;
      acc       <= '0;
      max_val   <= '0;
      class_idx <= '0;
      for (int j = 0; j < OUT_DIM; j++) begin
        out_vec[j] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= BIAS;
            neuron <= '0;
            busy   <= 1'b1;
          end
        end
        BIAS: begin
          acc   <= ACC_W'(biases[neuron]);
          chunk <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc + lane_sum;
          if (chunk == LAST_CHUNK) begin
            chunk <= '0;
            state <= STORE;
          end else begin
            chunk <= chunk + CH_W'(1);
          end
        end
        STORE: begin
          out_vec[neuron] <= store_val;
          // Strictly-greater replacement keeps the lowest index on ties
          if (neuron == '0 || store_val > max_val) begin
            max_val   <= store_val;
            class_idx <= neuron;
          end
          if (neuron == LAST_NEURON) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            neuron <= neuron + NEU_W'(1);
            state  <= BIAS;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
